// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART frame controller.
package uart_frame_pkg;

    typedef enum logic [1:0] {S_IDLE, S_LEN, S_PAY, S_CHK} state_t;

    localparam logic [7:0] HDR_DEFAULT = 8'hAA;
    localparam int         ERR_CNT_W   = 8;

    function automatic logic len_ok(input logic [7:0] len, input int max_len);
        return (len != 8'd0) && (int'(len) <= max_len);
    endfunction

endpackage

// File: rtl/uart_frame_timeout.sv
// Inter-byte idle timer: down-counter reloaded on clear, expired pulses at terminal count.
module uart_frame_timeout #(
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);
    localparam int               CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] LOAD  = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_cnt <= LOAD;
        end else if (i_enable && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    // a clear in the same cycle suppresses expiry, so an arriving byte always wins
    assign o_expired = i_enable && !i_clear && (r_cnt == '0);

endmodule

// File: rtl/uart_frame_ctrl.sv
// Frame parser HDR,LEN,PAYLOAD[LEN],CHK -> display register; optional byte echo via UART_FRAME_ECHO_EN.
//  state  | meaning
//  S_IDLE | waiting for HDR, other bytes ignored
//  S_LEN  | expecting length byte
//  S_PAY  | collecting payload bytes into shadow
//  S_CHK  | expecting checksum (XOR of LEN and payload)
module uart_frame_ctrl
    import uart_frame_pkg::*;
#(
    parameter logic [7:0] HDR         = HDR_DEFAULT,
    parameter int         MAX_LEN     = 4,
    parameter int         TIMEOUT_CYC = 1_000_000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rx_valid,
    input  logic [7:0]             rx_data,
    output logic [8*MAX_LEN-1:0]   disp_data,
    output logic                   disp_update,
    output logic                   frame_err,
    output logic [ERR_CNT_W-1:0]   err_cnt,
    output logic                   busy
`ifdef UART_FRAME_ECHO_EN
    ,
    output logic                   tx_start,
    output logic [7:0]             tx_data,
    input  logic                   tx_busy
`endif
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    state_t                 r_state, w_state_nxt;
    logic [LEN_W-1:0]       r_len, r_idx;
    logic [7:0]             r_chk;
    logic [8*MAX_LEN-1:0]   r_shadow, r_disp;
    logic [MAX_LEN-1:0]     r_mask;
    logic                   r_commit_q, r_update, r_err;
    logic [ERR_CNT_W-1:0]   r_err_cnt;
    logic                   w_busy, w_tmo, w_len_ok, w_last_pay, w_commit, w_err;

    assign w_busy     = (r_state != S_IDLE);
    assign w_len_ok   = len_ok(rx_data, MAX_LEN);
    assign w_last_pay = (r_idx == (r_len - LEN_W'(1)));

    uart_frame_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (rx_valid || !w_busy),
        .i_enable (w_busy),
        .o_expired(w_tmo)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (rx_valid) begin
            case (r_state)
                S_IDLE:  if (rx_data == HDR) w_state_nxt = S_LEN;
                S_LEN:   w_state_nxt = w_len_ok ? S_PAY : S_IDLE;
                S_PAY:   if (w_last_pay) w_state_nxt = S_CHK;
                S_CHK:   w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end else if (w_tmo) begin
            w_state_nxt = S_IDLE;
        end
    end

    always_comb begin
        w_commit = rx_valid && (r_state == S_CHK) && (rx_data == r_chk);
        w_err    = w_tmo
                || (rx_valid && (r_state == S_LEN) && !w_len_ok)
                || (rx_valid && (r_state == S_CHK) && (rx_data != r_chk));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_len    <= '0;
            r_idx    <= '0;
            r_chk    <= '0;
            r_shadow <= '0;
            r_mask   <= '0;
        end else if (rx_valid) begin
            case (r_state)
                S_LEN: begin
                    if (w_len_ok) begin
                        r_len  <= rx_data[LEN_W-1:0];
                        r_chk  <= rx_data;
                        r_idx  <= '0;
                        r_mask <= '0;
                    end
                end
                S_PAY: begin
                    for (int k = 0; k < MAX_LEN; k++) begin
                        if (r_idx == LEN_W'(k)) begin
                            r_shadow[8*k +: 8] <= rx_data;
                            r_mask[k]          <= 1'b1;
                        end
                    end
                    r_chk <= r_chk ^ rx_data;
                    r_idx <= r_idx + LEN_W'(1);
                end
                default: ;
            endcase
        end
    end

    // bytes not written by this frame keep their previous display value
    always_ff @(posedge clk) begin
        if (rst) begin
            r_disp     <= '0;
            r_commit_q <= 1'b0;
            r_update   <= 1'b0;
            r_err      <= 1'b0;
            r_err_cnt  <= '0;
        end else begin
            r_commit_q <= w_commit;
            r_update   <= r_commit_q;
            r_err      <= w_err;
            if (w_commit) begin
                for (int k = 0; k < MAX_LEN; k++) begin
                    if (r_mask[k]) r_disp[8*k +: 8] <= r_shadow[8*k +: 8];
                end
            end
            if (w_err && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
        end
    end

    assign disp_data   = r_disp;
    assign disp_update = r_update;
    assign frame_err   = r_err;
    assign err_cnt     = r_err_cnt;
    assign busy        = w_busy;

`ifdef UART_FRAME_ECHO_EN
    logic       r_hold_full, r_tx_start;
    logic [7:0] r_hold_data, r_tx_data;

    // a byte arriving while the holding register is full replaces the older one
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_full <= 1'b0;
            r_hold_data <= '0;
            r_tx_start  <= 1'b0;
            r_tx_data   <= '0;
        end else begin
            r_tx_start <= 1'b0;
            if (r_hold_full && !tx_busy) begin
                r_tx_start  <= 1'b1;
                r_tx_data   <= r_hold_data;
                r_hold_full <= 1'b0;
            end
            if (rx_valid) begin
                r_hold_data <= rx_data;
                r_hold_full <= 1'b1;
            end
        end
    end

    assign tx_start = r_tx_start;
    assign tx_data  = r_tx_data;
`endif

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Bench for uart_frame_ctrl: frame table, directed corner sequences, random frames vs. a queue-based model.
`timescale 1ns/1ps
module tb_uart_frame_ctrl;
    localparam int         TCYC = 40;
    localparam int         MLEN = 4;
    localparam logic [7:0] HDR  = 8'hAA;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1, rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic [31:0] disp_data;
    logic        disp_update, frame_err, busy;
    logic [7:0]  err_cnt;
`ifdef UART_FRAME_ECHO_EN
    logic        tx_start, tx_busy = 1'b0;
    logic [7:0]  tx_data;
    int          n_tx = 0;
    logic [7:0]  last_tx = 8'h00;
`endif

    uart_frame_ctrl #(.HDR(HDR), .MAX_LEN(MLEN), .TIMEOUT_CYC(TCYC)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .disp_data  (disp_data),
        .disp_update(disp_update),
        .frame_err  (frame_err),
        .err_cnt    (err_cnt),
        .busy       (busy)
`ifdef UART_FRAME_ECHO_EN
        ,
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .tx_busy    (tx_busy)
`endif
    );

    int n_vec = 0, n_err = 0, n_upd = 0, n_ferr = 0;

    // Reference model: bytes of the frame in progress are kept in a queue and
    // the frame is judged when LEN is known or when the last byte arrives.
    logic [7:0]  mq[$];
    logic [31:0] m_disp = '0;
    logic [7:0]  m_cnt = '0, x;
    logic        m_upd = 0, m_commit_d = 0, m_err = 0, m_busy = 0, commit_now, err_now;
    int          silent = 0;

    always @(posedge clk) begin
        commit_now = 1'b0;
        err_now    = 1'b0;
        if (rst) begin
            mq.delete();
            silent = 0; m_disp = '0; m_cnt = '0;
            m_commit_d = 0; m_upd = 0; m_err = 0; m_busy = 0;
        end else begin
            if (rx_valid) begin
                silent = 0;
                if (mq.size() == 0) begin
                    if (rx_data == HDR) mq.push_back(rx_data);
                end else begin
                    mq.push_back(rx_data);
                    if (mq.size() == 2 && (mq[1] == 8'd0 || int'(mq[1]) > MLEN)) begin
                        err_now = 1'b1;
                        mq.delete();
                    end else if (mq.size() == int'(mq[1]) + 3) begin
                        x = '0;
                        for (int i = 1; i < mq.size() - 1; i++) x ^= mq[i];
                        if (x == mq[mq.size()-1]) begin
                            commit_now = 1'b1;
                            for (int k = 0; k < int'(mq[1]); k++) m_disp[8*k +: 8] = mq[2+k];
                        end else begin
                            err_now = 1'b1;
                        end
                        mq.delete();
                    end
                end
            end else if (mq.size() != 0) begin
                silent++;
                if (silent == TCYC) begin
                    err_now = 1'b1;
                    mq.delete();
                end
            end
            m_upd      = m_commit_d;
            m_commit_d = commit_now;
            m_err      = err_now;
            if (err_now && m_cnt != 8'hFF) m_cnt++;
            m_busy = (mq.size() != 0);
        end
    end

    task automatic check_model();
        n_vec++;
        if (disp_update) n_upd++;
        if (frame_err)   n_ferr++;
`ifdef UART_FRAME_ECHO_EN
        if (tx_start) begin n_tx++; last_tx = tx_data; end
`endif
        if (disp_data !== m_disp || disp_update !== m_upd || frame_err !== m_err ||
            err_cnt !== m_cnt || busy !== m_busy) begin
            n_err++;
            $display("FAIL model t=%0t: got disp=%h upd=%b err=%b cnt=%h busy=%b, want disp=%h upd=%b err=%b cnt=%h busy=%b",
                     $time, disp_data, disp_update, frame_err, err_cnt, busy,
                     m_disp, m_upd, m_err, m_cnt, m_busy);
        end
    endtask

    task automatic expect_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic r);
        rx_valid = v;
        rx_data  = d;
        rst      = r;
        @(negedge clk);
        check_model();
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        step(1'b1, b, 1'b0);
        repeat (gap) step(1'b0, 8'($urandom_range(0, 255)), 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 8'h00, 1'b0);
    endtask

    function automatic int rgap();
        int sel;
        sel = $urandom_range(0, 29);
        if (sel == 0) return TCYC - 1;
        if (sel == 1) return TCYC;
        if (sel == 2) return TCYC + 2;
        return $urandom_range(0, 3);
    endfunction

    typedef struct {
        logic [63:0] bytes;
        int          n;
        logic [31:0] disp;
        logic [7:0]  cnt;
        int          upd;
        int          ferr;
    } vec_t;
    vec_t tv[9];

    initial begin
        int          u0, f0, kind, len;
        logic [7:0]  b, chk;

        tv[0] = '{{8'hAA,8'h02,8'h12,8'h34,8'h24,8'h00,8'h00,8'h00}, 5, 32'h0000_3412, 8'd0, 1, 0};
        tv[1] = '{{8'hAA,8'h01,8'h55,8'h00,8'h00,8'h00,8'h00,8'h00}, 4, 32'h0000_3412, 8'd1, 0, 1};
        tv[2] = '{{8'hAA,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, 2, 32'h0000_3412, 8'd2, 0, 1};
        tv[3] = '{{8'hAA,8'h05,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, 2, 32'h0000_3412, 8'd3, 0, 1};
        tv[4] = '{{8'hAA,8'h04,8'h11,8'h22,8'h33,8'h44,8'h40,8'h00}, 7, 32'h4433_2211, 8'd3, 1, 0};
        tv[5] = '{{8'h00,8'hAA,8'h01,8'hAA,8'hAB,8'h00,8'h00,8'h00}, 5, 32'h4433_22AA, 8'd3, 1, 0};
        tv[6] = '{{8'hAA,8'h03,8'hAA,8'hBB,8'hCC,8'hDE,8'h00,8'h00}, 6, 32'h44CC_BBAA, 8'd3, 1, 0};
        tv[7] = '{{8'hAA,8'h02,8'h01,8'h02,8'h00,8'h00,8'h00,8'h00}, 5, 32'h44CC_BBAA, 8'd4, 0, 1};
        tv[8] = '{{8'hAA,8'h03,8'hFF,8'hFF,8'hFF,8'hFC,8'h00,8'h00}, 6, 32'h44FF_FFFF, 8'd4, 1, 0};

        // reset state
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        expect_val("rst disp", disp_data, 32'h0);
        expect_val("rst cnt", {24'h0, err_cnt}, 32'h0);
        expect_val("rst flags", {29'h0, busy, frame_err, disp_update}, 32'h0);
        idle(2);

        // frame table
        for (int i = 0; i < 9; i++) begin
            u0 = n_upd;
            f0 = n_ferr;
            for (int k = 0; k < tv[i].n; k++) send(tv[i].bytes[63-8*k -: 8], 1);
            idle(3);
            expect_val($sformatf("tbl%0d disp", i), disp_data, tv[i].disp);
            expect_val($sformatf("tbl%0d cnt", i), {24'h0, err_cnt}, {24'h0, tv[i].cnt});
            expect_val($sformatf("tbl%0d busy", i), {31'h0, busy}, 32'h0);
            expect_val($sformatf("tbl%0d upd", i), n_upd - u0, tv[i].upd);
            expect_val($sformatf("tbl%0d ferr", i), n_ferr - f0, tv[i].ferr);
        end

        // timeout after TCYC silent cycles
        step(1'b0, 8'h00, 1'b1);
        idle(1);
        send(HDR, 0); send(8'h03, 0); send(8'h01, 0);
        idle(TCYC - 1);
        expect_val("tmo before", {30'h0, busy, frame_err}, 32'h2);
        idle(1);
        expect_val("tmo fire", {30'h0, busy, frame_err}, 32'h1);
        expect_val("tmo cnt", {24'h0, err_cnt}, 32'h1);
        send(HDR, 0); send(8'h01, 0); send(8'h07, 0); send(8'h06, 0);
        idle(3);
        expect_val("tmo next disp", disp_data, 32'h0000_0007);

        // byte arriving in the expiry cycle wins
        send(HDR, 0); send(8'h01, 0);
        idle(TCYC - 1);
        send(8'h55, 0);
        expect_val("tmo race", {30'h0, busy, frame_err}, 32'h2);
        send(8'h54, 0);
        idle(3);
        expect_val("tmo race disp", disp_data, 32'h0000_0055);
        expect_val("tmo race cnt", {24'h0, err_cnt}, 32'h1);

        // random frames against the model
        for (int f = 0; f < 300; f++) begin
            kind = $urandom_range(0, 5);
            len  = $urandom_range(1, MLEN);
            if (kind == 5) begin
                send(8'($urandom_range(0, 255)), rgap());
            end else if (kind == 4) begin
                send(HDR, rgap());
                b = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(MLEN + 1, 255));
                send(b, rgap());
            end else begin
                send(HDR, rgap());
                send(8'(len), rgap());
                chk = 8'(len);
                for (int k = 0; k < len; k++) begin
                    b = 8'($urandom_range(0, 255));
                    chk ^= b;
                    send(b, rgap());
                end
                if (kind == 3) chk ^= 8'($urandom_range(1, 255));
                send(chk, rgap());
            end
        end
        idle(TCYC + 2);

        // error counter saturation
        repeat (260) begin
            send(HDR, 0);
            send(8'h00, 0);
        end
        idle(2);
        expect_val("sat cnt", {24'h0, err_cnt}, 32'hFF);

        // reset in the middle of a frame
        send(HDR, 0); send(8'h02, 0); send(8'h12, 0);
        expect_val("mid busy", {31'h0, busy}, 32'h1);
        f0 = n_ferr;
        step(1'b0, 8'h00, 1'b1);
        expect_val("mid rst disp", disp_data, 32'h0);
        expect_val("mid rst cnt", {24'h0, err_cnt}, 32'h0);
        expect_val("mid rst flags", {29'h0, busy, frame_err, disp_update}, 32'h0);
        send(8'h34, 0); send(8'h24, 0);
        idle(4);
        expect_val("mid no pulse", n_ferr - f0, 0);
        expect_val("mid disp kept", disp_data, 32'h0);

`ifdef UART_FRAME_ECHO_EN
        idle(3);
        n_tx    = 0;
        tx_busy = 1'b1;
        send(8'h41, 0); send(8'h42, 0);
        idle(3);
        tx_busy = 1'b0;
        idle(4);
        expect_val("echo count", n_tx, 1);
        expect_val("echo data", {24'h0, last_tx}, 32'h42);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
